// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch and data ports), the shared
// single-port RAM and the memory arbiter. The arbiter uses the slave
// modport; the pipeline/RAM environment uses the master modport.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  // instruction-fetch port
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;

  // data port
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [SW-1:0] mem_sel_i;
  logic          mem_ack_o;
  logic [DW-1:0] mem_rdata_o;

  logic          flush_i;

  // shared RAM
  logic          ram_ce_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [SW-1:0] ram_sel_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  // stall requests
  logic          stallreq_if_o;
  logic          stallreq_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_rdata_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    output mem_ack_o, mem_rdata_o,
    input  flush_i,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
    input  ram_rdata_i,
    output stallreq_if_o, stallreq_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_rdata_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_sel_i,
    input  mem_ack_o, mem_rdata_o,
    output flush_i,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o,
    output ram_rdata_i,
    input  stallreq_if_o, stallreq_mem_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port RAM with
// one-cycle read latency. A request is granted combinationally in IDLE,
// the ack comes out of WAIT one cycle later.
//
// Build option: define ARB_FAIR_EN to alternate grants on a conflict
// between fetch and data; otherwise the data port always wins.
//
// state | meaning
// IDLE  | RAM free; grant an eligible request this cycle
// WAIT  | RAM read/write in flight; ack the recorded grantee
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = DW / 8;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {GNT_IF, GNT_MEM} grant_e;

  state_e state_q, state_d;
  grant_e grant_q, grant_d;

  logic if_elig;
  logic pick_mem;

  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_sel;
  logic [DW-1:0] ram_wdata;
  logic          if_ack, mem_ack;
  logic [DW-1:0] if_rdata, mem_rdata;

  // A flushed fetch is never worth starting.
  assign if_elig = bus.if_req_i & ~bus.flush_i;

`ifdef ARB_FAIR_EN
  // On a conflict, the port that did not win last time gets the RAM.
  assign pick_mem = bus.mem_req_i & (~if_elig | (grant_q == GNT_IF));
`else
  assign pick_mem = bus.mem_req_i;
`endif

  // State and last-grant registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= GNT_IF;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Grant decision, RAM drive and ack generation.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    if_rdata  = '0;
    mem_rdata = '0;

    case (state_q)
      IDLE: begin
        if (if_elig || bus.mem_req_i) begin
          state_d = WAIT;
          ram_ce  = 1'b1;
          if (pick_mem) begin
            grant_d   = GNT_MEM;
            ram_we    = bus.mem_we_i;
            ram_addr  = bus.mem_addr_i;
            ram_sel   = bus.mem_sel_i;
            ram_wdata = bus.mem_wdata_i;
          end else begin
            grant_d  = GNT_IF;
            ram_addr = bus.if_addr_i;
            ram_sel  = '1;
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (grant_q == GNT_MEM) begin
          mem_ack   = 1'b1;
          mem_rdata = bus.ram_rdata_i;
        end else if (!bus.flush_i) begin
          if_ack   = 1'b1;
          if_rdata = bus.ram_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced quiet the instant reset is asserted, not at the next edge.
    if (!rst) begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_sel   = '0;
      ram_wdata = '0;
      if_ack    = 1'b0;
      mem_ack   = 1'b0;
      if_rdata  = '0;
      mem_rdata = '0;
    end
  end

  assign bus.ram_ce_o    = ram_ce;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_sel_o   = ram_sel;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.if_ack_o    = if_ack;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.mem_ack_o   = mem_ack;
  assign bus.mem_rdata_o = mem_rdata;

  assign bus.stallreq_if_o  = bus.if_req_i & ~if_ack;
  assign bus.stallreq_mem_o = bus.mem_req_i & ~mem_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, a transaction-level model of
// the arbiter checked every cycle, and literal expectations at key points.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM: one-cycle read latency, byte-enabled writes, preloaded on the first edge.
  logic [31:0] ram [0:255];
  logic [31:0] ram_q = '0;
  logic        preloaded = 1'b0;
  assign bus.ram_rdata_i = ram_q;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + i;
      ram[64]   <= 32'h3C01_0001;
      ram[8]    <= 32'h1122_3344;
      preloaded <= 1'b1;
    end else if (bus.ram_ce_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_sel_o[b]) ram[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        ram_q <= ram[bus.ram_addr_o[9:2]];
      end
    end
  end

  // Model: an access occupies the RAM for the grant cycle plus the ack cycle.
  int          m_pend = 0;   // 0 none, 1 fetch in flight, 2 data in flight
  int          m_last = 1;   // last port granted
  logic [31:0] m_data = '0;
  bit          m_we   = 1'b0;
  int          win;
  bit          ie, me, wr_ack;
  logic        e_ce, e_we, e_ifack, e_memack;
  logic [31:0] e_addr, e_wdata, e_ifr, e_memr;
  logic [3:0]  e_sel;

  always @(negedge clk) begin
    e_ce = 0; e_we = 0; e_addr = '0; e_sel = '0; e_wdata = '0;
    e_ifack = 0; e_memack = 0; e_ifr = '0; e_memr = '0; wr_ack = 0;
    if (!rst) begin
      m_pend = 0;
      m_last = 1;
    end else if (m_pend != 0) begin
      if (m_pend == 2) begin
        e_memack = 1;
        e_memr   = m_data;
        wr_ack   = m_we;
      end else if (!bus.flush_i) begin
        e_ifack = 1;
        e_ifr   = m_data;
      end
      m_pend = 0;
    end else begin
      ie  = bus.if_req_i && !bus.flush_i;
      me  = bus.mem_req_i;
      win = 0;
      if (ie && me) win = FAIR ? ((m_last == 1) ? 2 : 1) : 2;
      else if (me)  win = 2;
      else if (ie)  win = 1;
      if (win == 2) begin
        e_ce = 1; e_we = bus.mem_we_i; e_addr = bus.mem_addr_i;
        e_sel = bus.mem_sel_i; e_wdata = bus.mem_wdata_i;
        m_data = ram[bus.mem_addr_i[9:2]];
        m_we   = bus.mem_we_i;
      end else if (win == 1) begin
        e_ce = 1; e_addr = bus.if_addr_i; e_sel = 4'hF;
        m_data = ram[bus.if_addr_i[9:2]];
        m_we   = 1'b0;
      end
      if (win != 0) begin
        m_pend = win;
        m_last = win;
      end
    end
    chk("m_ram_ce", bus.ram_ce_o, e_ce);
    chk("m_ram_we", bus.ram_we_o, e_we);
    chk("m_ram_addr", bus.ram_addr_o, e_addr);
    chk("m_ram_sel", bus.ram_sel_o, e_sel);
    chk("m_ram_wdata", bus.ram_wdata_o, e_wdata);
    chk("m_if_ack", bus.if_ack_o, e_ifack);
    chk("m_mem_ack", bus.mem_ack_o, e_memack);
    chk("m_if_rdata", bus.if_rdata_o, e_ifr);
    if (!wr_ack) chk("m_mem_rdata", bus.mem_rdata_o, e_memr);
    chk("m_stall_if", bus.stallreq_if_o, bus.if_req_i & ~e_ifack);
    chk("m_stall_mem", bus.stallreq_mem_o, bus.mem_req_i & ~e_memack);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [5:0] ifb, memb, ceb;

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_addr_i = '0;
    bus.mem_wdata_i = '0; bus.mem_sel_i = '0; bus.flush_i = 0;

    // reset: outputs quiet, stall request follows the request
    repeat (2) nxt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    smp();
    chk("rst_stall_if", bus.stallreq_if_o, 1);
    chk("rst_ram_ce", bus.ram_ce_o, 0);
    chk("rst_if_ack", bus.if_ack_o, 0);
    nxt();

    // fetch at 0x100
    rst = 1;
    smp();
    chk("f_ce_c0", bus.ram_ce_o, 1);
    chk("f_stall_c0", bus.stallreq_if_o, 1);
    chk("f_addr_c0", bus.ram_addr_o, 32'h100);
    nxt(); smp();
    chk("f_ack_c1", bus.if_ack_o, 1);
    chk("f_rdata_c1", bus.if_rdata_o, 32'h3C01_0001);
    chk("f_stall_c1", bus.stallreq_if_o, 0);
    chk("f_ce_c1", bus.ram_ce_o, 0);
    nxt();
    bus.if_req_i = 0;
    smp();

    // data write to 0x20, low half
    nxt();
    bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_addr_i = 32'h20;
    bus.mem_sel_i = 4'b0011; bus.mem_wdata_i = 32'hAABB_CCDD;
    smp();
    chk("w_ce_c0", bus.ram_ce_o, 1);
    chk("w_we_c0", bus.ram_we_o, 1);
    chk("w_sel_c0", bus.ram_sel_o, 4'b0011);
    nxt(); smp();
    chk("w_ack_c1", bus.mem_ack_o, 1);
    chk("w_ifack_c1", bus.if_ack_o, 0);
    nxt();
    bus.mem_req_i = 0; bus.mem_we_i = 0;
    smp();

    // read back 0x20
    nxt();
    bus.mem_req_i = 1; bus.mem_addr_i = 32'h20; bus.mem_sel_i = 4'hF;
    smp(); nxt(); smp();
    chk("rb_rdata", bus.mem_rdata_o, 32'h1122_CCDD);
    nxt();
    bus.mem_req_i = 0;
    smp();

    // both ports held for 6 cycles after a fresh reset
    nxt(); rst = 0;
    nxt(); rst = 1;
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 32'h40; bus.mem_sel_i = 4'hF;
    for (int k = 0; k < 6; k++) begin
      smp();
      ifb[k] = bus.if_ack_o; memb[k] = bus.mem_ack_o; ceb[k] = bus.ram_ce_o;
      nxt();
    end
    bus.if_req_i = 0; bus.mem_req_i = 0;
    chk("c_ce_pattern", ceb, 6'b010101);
`ifdef ARB_FAIR_EN
    chk("c_mem_acks", memb, 6'b100010);
    chk("c_if_acks", ifb, 6'b001000);
`else
    chk("c_mem_acks", memb, 6'b101010);
    chk("c_if_acks", ifb, 6'b000000);
`endif
    smp();

    // flush during the fetch ack cycle, then flush blocks new fetch grants
    nxt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    smp();
    chk("fl_ce_c0", bus.ram_ce_o, 1);
    nxt(); bus.flush_i = 1;
    smp();
    chk("fl_ack_c1", bus.if_ack_o, 0);
    chk("fl_rdata_c1", bus.if_rdata_o, 0);
    nxt(); smp();
    chk("fl_no_grant", bus.ram_ce_o, 0);
    nxt(); bus.flush_i = 0;
    smp();
    chk("fl_regrant", bus.ram_ce_o, 1);
    nxt(); smp();
    chk("fl_ack_after", bus.if_ack_o, 1);
    nxt(); bus.if_req_i = 0;
    smp();

    // reset asserted in WAIT
    nxt();
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    smp();
    chk("rw_ce_c0", bus.ram_ce_o, 1);
    nxt(); rst = 0;
    #1;
    chk("rw_ce", bus.ram_ce_o, 0);
    chk("rw_if_ack", bus.if_ack_o, 0);
    chk("rw_if_rdata", bus.if_rdata_o, 0);
    chk("rw_mem_ack", bus.mem_ack_o, 0);
    nxt(); rst = 1; bus.if_req_i = 0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("rw_no_ack", bus.if_ack_o, 0);
      nxt();
    end
    bus.if_req_i = 1; bus.if_addr_i = 32'h104;
    smp();
    chk("rw_next_ce", bus.ram_ce_o, 1);
    nxt(); smp();
    chk("rw_next_ack", bus.if_ack_o, 1);
    chk("rw_next_rdata", bus.if_rdata_o, 32'h1000_0041);
    nxt(); bus.if_req_i = 0;
    smp(); nxt();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width in bits; byte-enable width is DW/8.
REQ-003 The block SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port if_req_i  input  1  instruction-fetch read request.
REQ-006 The block SHALL have port if_addr_i  input  AW  fetch address.
REQ-007 The block SHALL have port if_ack_o  output  1  fetch completion pulse.
REQ-008 The block SHALL have port if_rdata_o  output  DW  fetch data, valid only while if_ack_o=1.
REQ-009 The block SHALL have port mem_req_i / mem_we_i  input  1 each  data request and write flag.
REQ-010 The block SHALL have port mem_addr_i / mem_wdata_i / mem_sel_i  input  AW / DW / DW/8  data-access address, write data and byte enables.
REQ-011 The block SHALL have port mem_ack_o / mem_rdata_o  output  1 / DW  data completion pulse and read data.
REQ-012 The block SHALL have port flush_i  input  1  pipeline flush; squashes fetches.
REQ-013 The block SHALL have ports ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o  output  1/1/AW/DW/8/DW  shared single-port RAM controls.
REQ-014 The block SHALL have port ram_rdata_i  input  DW  RAM read data, valid one cycle after ram_ce_o.
REQ-015 The block SHALL have ports stallreq_if_o / stallreq_mem_o  output  1 each  stall requests to the pipeline controller.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-017 In IDLE with at least one eligible request, the block SHALL grant in the same cycle, drive ram_ce_o=1 with the granted port's signals, record the grant and enter WAIT.
REQ-018 A fetch request SHALL be eligible only when if_req_i=1 and flush_i=0.
REQ-019 An IF grant SHALL drive ram_we_o=0, ram_sel_o=all ones and ram_wdata_o=0; a MEM grant SHALL pass mem_we_i, mem_sel_i, mem_addr_i and mem_wdata_i unchanged.
REQ-020 In WAIT, the block SHALL hold ram_ce_o=0, pulse the ack of the recorded grantee for exactly one cycle, drive the matching rdata_o from ram_rdata_i, and return to IDLE.
REQ-021 Access latency SHALL be 1 cycle from grant to ack; peak throughput SHALL be one access per 2 cycles.
REQ-022 Requests SHALL be ignored while in WAIT; a requester SHALL hold req and its payload until its ack, and a request still asserted in the cycle after the ack SHALL be treated as a new request.
REQ-023 If flush_i=1 in WAIT with an IF grant, if_ack_o SHALL remain 0; the RAM read is discarded.
REQ-024 The rdata of a port not being acked SHALL be 0.
REQ-025 stallreq_x_o SHALL equal x_req_i AND NOT x_ack_o, combinationally.
REQ-026 For writes, mem_ack_o SHALL pulse in WAIT, and mem_rdata_o SHALL be don't-care.

Reset
REQ-027 While rst=0, the FSM SHALL be in IDLE, the grant register SHALL hold IF, and all outputs SHALL be 0 except stallreq_x_o, which follows x_req_i.
REQ-028 If reset is asserted while in WAIT, the block SHALL abandon the access and produce no ack after rst rises.

Configuration
REQ-029 With ARB_FAIR_EN defined, a simultaneous eligible IF and MEM request SHALL be granted to the port not granted last (alternating).
REQ-030 Without ARB_FAIR_EN, MEM SHALL always win a conflict; fetch starvation under continuous MEM requests is accepted.
REQ-031 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-032 Bench SHALL cover: if_req=1, addr=0x100, RAM returns 0x3C010001 -> ram_ce in cycle 0, if_ack=1 with if_rdata=0x3C010001 in cycle 1, stallreq_if=1 in cycle 0 only.
REQ-033 Bench SHALL cover: MEM write, addr=0x20, sel=0b0011, wdata=0xAABBCCDD -> ram_we=1, ram_sel=0b0011 in cycle 0; mem_ack in cycle 1; no if_ack.
REQ-034 Bench SHALL cover: both requests held 6 cycles -> without ARB_FAIR_EN, mem_ack at cycles 1, 3, 5 and no if_ack; with ARB_FAIR_EN, grant order MEM, IF, MEM from a reset state where the last grant is IF.
REQ-035 Bench SHALL cover: IF granted, flush_i=1 in cycle 1 -> if_ack stays 0; IF is not granted while flush_i=1.
REQ-036 Bench SHALL cover: rst to 0 during WAIT -> ram_ce, acks and rdata are 0 immediately; no ack after release; the next request is granted normally.
